// File: rtl/e_div_unit_pkg.sv
// Shared definitions for the execute-stage divide unit: op encodings, FSM states, width.
package e_div_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/e_div_unit.sv
// Iterative 32-step restoring divider for DIV/DIVU/REM/REMU; stalls the pipeline while busy
// and presents a registered quotient or remainder for one DONE cycle.
module e_div_unit
    import e_div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            E_div_start,
    input  logic [1:0]      E_div_op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            E_flush,
    output logic            div_stall,
    output logic            div_done,
    output logic [XLEN-1:0] E_div_out
);

    div_state_t      state, state_next;
    logic [5:0]      cnt;
    logic [XLEN-1:0] rem_q, quot_q, divisor_q;
    logic [1:0]      op_q;
    logic            sign1_q, sign2_q;

    logic            start_ok;
    logic            sign1, sign2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_by_zero, overflow, special;
    logic [XLEN-1:0] special_out;

    logic [XLEN:0]   partial;
    logic [XLEN-1:0] diff;
    logic            ge;
    logic [XLEN-1:0] rem_step, quot_step;
    logic [XLEN-1:0] quot_fix, rem_fix, final_out;

    always_comb begin
        start_ok    = (state == IDLE) && E_div_start && !E_flush;

        sign1       = operand1[XLEN-1] & ~E_div_op[0];
        sign2       = operand2[XLEN-1] & ~E_div_op[0];
        mag1        = sign1 ? (~operand1 + 1'b1) : operand1;
        mag2        = sign2 ? (~operand2 + 1'b1) : operand2;

        div_by_zero = (operand2 == '0);
        overflow    = !E_div_op[0] && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
        special     = div_by_zero || overflow;
        special_out = '0;
        if (div_by_zero)
            special_out = E_div_op[1] ? operand1 : '1;
        else if (overflow)
            special_out = E_div_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};

        // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder
        partial   = {rem_q, quot_q[XLEN-1]};
        ge        = (partial >= {1'b0, divisor_q});
        diff      = partial[XLEN-1:0] - divisor_q;
        rem_step  = ge ? diff : partial[XLEN-1:0];
        quot_step = {quot_q[XLEN-2:0], ge};

        quot_fix  = ((op_q == DIV_OP_DIV) && (sign1_q ^ sign2_q)) ? (~quot_step + 1'b1) : quot_step;
        rem_fix   = ((op_q == DIV_OP_REM) && sign1_q) ? (~rem_step + 1'b1) : rem_step;
        final_out = op_q[1] ? rem_fix : quot_fix;
    end

    always_comb begin
        state_next = state;
        div_stall  = 1'b0;
        div_done   = 1'b0;
        unique case (state)
            IDLE: begin
                div_stall = start_ok;
                if (start_ok)
                    state_next = special ? DONE : CALC;
            end
            CALC: begin
                div_stall = 1'b1;
                if (E_flush)
                    state_next = IDLE;
                else if (cnt == 6'd1)
                    state_next = DONE;
            end
            DONE: begin
                div_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            op_q      <= '0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            E_div_out <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                op_q      <= E_div_op;
                sign1_q   <= sign1;
                sign2_q   <= sign2;
                divisor_q <= mag2;
                quot_q    <= mag1;
                rem_q     <= '0;
                cnt       <= 6'd32;
                if (special)
                    E_div_out <= special_out;
            end else if ((state == CALC) && !E_flush) begin
                rem_q  <= rem_step;
                quot_q <= quot_step;
                cnt    <= cnt - 6'd1;
                if (cnt == 6'd1)
                    E_div_out <= final_out;
            end
        end
    end

endmodule
